// File: rtl/spram_loader_pkg.sv
// Shared types and constants for the SPRAM boot loader.
package spram_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    WR_DATA,
    WR_STB,
    RD_REQ,
    RD_SMP,
    RD_SEND,
    ACK,
    NAK,
    RUN
  } state_t;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;

  localparam int unsigned HDR_LEN = 4;

endpackage

// File: rtl/spram_loader.sv
// Boot loader in front of spram8: holds the CPU in reset, loads/dumps memory
// over a byte stream, then hands the memory bus to the CPU on 'G'.
module spram_loader
  import spram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = 15,
  parameter logic [7:0]  ACK_BYTE = 8'h4B,
  parameter logic [7:0]  NAK_BYTE = 8'h3F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              cpu_rst,
  input  logic              cpu_cs_n,
  input  logic              cpu_oe_n,
  input  logic              cpu_we_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              mem_cs_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              booted
);

  state_t            state, state_n;
  logic [1:0]        hdr_cnt;
  logic              is_wr;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       count;
  logic [7:0]        din;
  logic [7:0]        tx_q;
  logic              tx_v;

  logic              rx_fire, tx_fire;
  logic              tx_load, step;
  logic [7:0]        tx_byte;

  assign rx_ready = !rst && (state inside {IDLE, HDR, WR_DATA});
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_v && tx_ready;
  assign tx_valid = tx_v;
  assign tx_data  = tx_q;
  assign cpu_rst  = (state != RUN);
  assign booted   = (state == RUN);
  assign cpu_dout = mem_dout;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    tx_load = 1'b0;
    tx_byte = '0;
    step    = 1'b0;
    case (state)
      IDLE: if (rx_fire) begin
        if (rx_data == CMD_W || rx_data == CMD_R) begin
          state_n = HDR;
        end else if (rx_data == CMD_G) begin
          state_n = RUN;
        end else begin
          state_n = NAK;
          tx_load = 1'b1;
          tx_byte = NAK_BYTE;
        end
      end
      // The low length byte is still on rx_data here, so test the full count
      // before it is registered.
      HDR: if (rx_fire && hdr_cnt == 2'(HDR_LEN - 1)) begin
        if ({count[15:8], rx_data} == 16'h0000) begin
          state_n = ACK;
          tx_load = 1'b1;
          tx_byte = ACK_BYTE;
        end else begin
          state_n = is_wr ? WR_DATA : RD_REQ;
        end
      end
      WR_DATA: if (rx_fire) state_n = WR_STB;
      WR_STB: begin
        step = 1'b1;
        if (count == 16'd1) begin
          state_n = ACK;
          tx_load = 1'b1;
          tx_byte = ACK_BYTE;
        end else begin
          state_n = WR_DATA;
        end
      end
      RD_REQ: state_n = RD_SMP;
      RD_SMP: begin
        state_n = RD_SEND;
        tx_load = 1'b1;
        tx_byte = mem_dout;
      end
      RD_SEND: if (tx_fire) begin
        step = 1'b1;
        if (count == 16'd1) begin
          state_n = ACK;
          tx_load = 1'b1;
          tx_byte = ACK_BYTE;
        end else begin
          state_n = RD_REQ;
        end
      end
      ACK, NAK: if (tx_fire) state_n = IDLE;
      RUN: state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_cnt <= '0;
      is_wr   <= 1'b0;
      addr    <= '0;
      count   <= '0;
      din     <= '0;
      tx_q    <= '0;
      tx_v    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        hdr_cnt <= '0;
        if (rx_fire) is_wr <= (rx_data == CMD_W);
      end
      if (state == HDR && rx_fire) begin
        hdr_cnt <= hdr_cnt + 2'd1;
        case (hdr_cnt)
          2'd0:    addr[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
          2'd1:    addr[7:0]        <= rx_data;
          2'd2:    count[15:8]      <= rx_data;
          default: count[7:0]       <= rx_data;
        endcase
      end
      if (state == WR_DATA && rx_fire) din <= rx_data;
      if (step) begin
        addr  <= addr + ADDR_W'(1);
        count <= count - 16'd1;
      end
      if (tx_load) begin
        tx_q <= tx_byte;
        tx_v <= 1'b1;
      end else if (tx_fire) begin
        tx_v <= 1'b0;
      end
    end
  end

  // In RUN the CPU owns the bus; OE is masked while WE is low so the two
  // strobes can never overlap at the memory.
  always_comb begin
    mem_cs_n = 1'b1;
    mem_oe_n = 1'b1;
    mem_we_n = 1'b1;
    mem_addr = addr;
    mem_din  = din;
    case (state)
      WR_STB: begin
        mem_cs_n = 1'b0;
        mem_we_n = 1'b0;
      end
      RD_REQ, RD_SMP: begin
        mem_cs_n = 1'b0;
        mem_oe_n = 1'b0;
      end
      RUN: begin
        mem_cs_n = cpu_cs_n;
        mem_we_n = cpu_we_n;
        mem_oe_n = cpu_oe_n | ~cpu_we_n;
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spram_loader.sv
// Bench for spram_loader: table vectors, hand sequences and random commands
// checked against an array-based memory/response model.
module tb_spram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cpu_rst;
  logic        cpu_cs_n, cpu_oe_n, cpu_we_n;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        mem_cs_n, mem_oe_n, mem_we_n;
  logic [14:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        booted;

  always #5 clk = ~clk;

  spram_loader #(
    .ADDR_W  (15),
    .ACK_BYTE(8'h4B),
    .NAK_BYTE(8'h3F)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpu_rst(cpu_rst),
    .cpu_cs_n(cpu_cs_n), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .mem_cs_n(mem_cs_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .booted(booted)
  );

  // spram8 stand-in: synchronous write, read data valid the cycle after the request
  bit [7:0] sram [32768];
  always @(posedge clk) begin
    if (!mem_cs_n && !mem_we_n) sram[mem_addr] <= mem_din;
    if (!mem_cs_n && !mem_oe_n) mem_dout <= sram[mem_addr];
  end

  // Bus / stream observers (written only here, read by the main sequence)
  int          wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, overlap_err = 0, stab_err = 0;
  logic [22:0] wr_arr [int];
  logic [7:0]  tx_arr [int];

  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && !booted) begin
        if (!mem_cs_n && !mem_we_n) begin
          wr_arr[wr_cnt] = {mem_addr, mem_din};
          wr_cnt++;
        end
        if (!mem_cs_n && !mem_oe_n) rd_cnt++;
      end
      if (!mem_we_n && !mem_oe_n) overlap_err++;
      if (!rst && prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err++;
      if (!rst && tx_valid && tx_ready) begin
        tx_arr[tx_cnt] = tx_data;
        tx_cnt++;
      end
      prev_stall = !rst && tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  logic rand_ready = 1'b0;
  logic ready_man  = 1'b1;
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_man;
    end
  end

  // Reference model: flat byte array plus response rules
  bit [7:0] ref_mem [32768];
  int checks = 0, failures = 0;
  int tx_rd = 0, wr_rd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    int n  = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL rx_accept: byte %h not accepted within 200 cycles", b);
    end
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while ((tx_cnt - tx_rd) < n && t < 3000) begin
      tick();
      t++;
    end
    if ((tx_cnt - tx_rd) < n) begin
      checks++;
      failures++;
      $display("FAIL tx_wait: got=%0d required=%0d", tx_cnt - tx_rd, n);
    end
  endtask

  task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] ah, input logic [7:0] al,
                         input logic [15:0] len, input logic [7:0] data [16],
                         output logic [7:0] last);
    logic [7:0]  exp_tx [$];
    logic [22:0] exp_wr [$];
    int base, a;
    base = int'({ah[6:0], al});
    last = 8'hxx;
    if (cmd == 8'h57) begin
      for (int i = 0; i < int'(len); i++) begin
        a = (base + i) % 32768;
        ref_mem[a] = data[i];
        exp_wr.push_back({a[14:0], data[i]});
      end
      exp_tx.push_back(8'h4B);
    end else if (cmd == 8'h52) begin
      for (int i = 0; i < int'(len); i++) exp_tx.push_back(ref_mem[(base + i) % 32768]);
      exp_tx.push_back(8'h4B);
    end else begin
      exp_tx.push_back(8'h3F);
    end
    send_byte(cmd);
    if (cmd == 8'h57 || cmd == 8'h52) begin
      send_byte(ah);
      send_byte(al);
      send_byte(len[15:8]);
      send_byte(len[7:0]);
      if (cmd == 8'h57)
        for (int i = 0; i < int'(len); i++) send_byte(data[i]);
    end
    wait_tx(exp_tx.size());
    tick(3);
    foreach (exp_tx[i]) begin
      if (tx_rd < tx_cnt) begin
        chk($sformatf("tx_byte cmd=%h i=%0d", cmd, i), tx_arr[tx_rd], exp_tx[i]);
        last = tx_arr[tx_rd];
        tx_rd++;
      end
    end
    chk("tx_extra", tx_cnt - tx_rd, 0);
    tx_rd = tx_cnt;
    chk($sformatf("wr_count cmd=%h", cmd), wr_cnt - wr_rd, exp_wr.size());
    foreach (exp_wr[i]) begin
      if (wr_rd < wr_cnt) begin
        chk($sformatf("wr_addr_data i=%0d", i), wr_arr[wr_rd], exp_wr[i]);
        wr_rd++;
      end
    end
    wr_rd = wr_cnt;
  endtask

  typedef struct {
    logic [7:0]  cmd, ah, al;
    logic [15:0] len;
    logic [7:0]  d0, d1, d2;
    logic [7:0]  last;
    int          wr;
    int          rd;
  } vec_t;

  initial begin
    vec_t        vt [7];
    logic [7:0]  dat [16];
    logic [7:0]  last;
    int          w0, r0, t;
    logic [7:0]  ah, al, c;
    logic [15:0] len;

    vt[0] = '{8'h57, 8'h00, 8'h10, 16'd3, 8'hAA, 8'hBB, 8'hCC, 8'h4B, 3, 0};
    vt[1] = '{8'h52, 8'h00, 8'h10, 16'd3, 8'h00, 8'h00, 8'h00, 8'h4B, 0, 6};
    vt[2] = '{8'h57, 8'hFF, 8'hFF, 16'd2, 8'h11, 8'h22, 8'h00, 8'h4B, 2, 0};
    vt[3] = '{8'h52, 8'h7F, 8'hFF, 16'd2, 8'h00, 8'h00, 8'h00, 8'h4B, 0, 4};
    vt[4] = '{8'h57, 8'h00, 8'h00, 16'd0, 8'h00, 8'h00, 8'h00, 8'h4B, 0, 0};
    vt[5] = '{8'h00, 8'h00, 8'h00, 16'd0, 8'h00, 8'h00, 8'h00, 8'h3F, 0, 0};
    vt[6] = '{8'h52, 8'h80, 8'h11, 16'd1, 8'h00, 8'h00, 8'h00, 8'h4B, 0, 2};

    // CPU bus active before boot: the loader must ignore it
    cpu_cs_n = 1'b0; cpu_we_n = 1'b0; cpu_oe_n = 1'b1;
    cpu_addr = 15'h1234; cpu_din = 8'hEE;
    rx_data  = 8'h57; rx_valid = 1'b1;
    rst = 1'b1;
    tick(3);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_booted", booted, 0);
    chk("rst_strobes", {mem_cs_n, mem_oe_n, mem_we_n}, 3'b111);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    rx_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_rx_ready", rx_ready, 1);

    for (int v = 0; v < 7; v++) begin
      foreach (dat[i]) dat[i] = '0;
      dat[0] = vt[v].d0; dat[1] = vt[v].d1; dat[2] = vt[v].d2;
      w0 = wr_cnt;
      r0 = rd_cnt;
      run_cmd(vt[v].cmd, vt[v].ah, vt[v].al, vt[v].len, dat, last);
      chk($sformatf("vec%0d_last_resp", v), last, vt[v].last);
      chk($sformatf("vec%0d_wr_strobes", v), wr_cnt - w0, vt[v].wr);
      chk($sformatf("vec%0d_rd_strobes", v), rd_cnt - r0, vt[v].rd);
    end

    // Read-back with a 5-cycle stall on the second byte
    ready_man = 1'b1;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h00); send_byte(8'h03);
    wait_tx(1);
    ready_man = 1'b0;
    t = 0;
    while (!tx_valid && t < 50) begin
      tick();
      t++;
    end
    r0 = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall_tx_data%0d", i), {tx_valid, tx_data}, {1'b1, 8'hBB});
    end
    chk("stall_no_extra_read", rd_cnt - r0, 0);
    ready_man = 1'b1;
    wait_tx(4);
    tick(3);
    chk("stall_b0", tx_arr[tx_rd], 8'hAA);
    chk("stall_b1", tx_arr[tx_rd + 1], 8'hBB);
    chk("stall_b2", tx_arr[tx_rd + 2], 8'hCC);
    chk("stall_b3", tx_arr[tx_rd + 3], 8'h4B);
    chk("stall_tx_count", tx_cnt - tx_rd, 4);
    tx_rd = tx_cnt;

    // Reset after the first of three data bytes
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h5A);
    t = 0;
    while (wr_cnt == wr_rd && t < 50) begin
      tick();
      t++;
    end
    rst = 1'b1;
    tick();
    chk("midrst_strobes", {mem_cs_n, mem_oe_n, mem_we_n}, 3'b111);
    chk("midrst_cpu_rst", cpu_rst, 1);
    chk("midrst_tx_valid", tx_valid, 0);
    rst = 1'b0;
    tick();
    chk("midrst_idle_ready", rx_ready, 1);
    chk("midrst_wr_count", wr_cnt - wr_rd, 1);
    chk("midrst_wr", wr_arr[wr_rd], {15'h0100, 8'h5A});
    wr_rd = wr_cnt;
    tx_rd = tx_cnt;
    ref_mem[15'h0100] = 8'h5A;
    foreach (dat[i]) dat[i] = '0;
    run_cmd(8'h52, 8'h01, 8'h00, 16'd2, dat, last);

    // Random commands with random sink back-pressure
    rand_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int k;
      k   = $urandom_range(0, 9);
      ah  = 8'($urandom);
      al  = 8'($urandom);
      len = 16'($urandom_range(1, 10));
      foreach (dat[i]) dat[i] = 8'($urandom);
      if (k == 0) begin
        ah = {ah[7], 7'h7F};
        al = 8'($urandom_range(248, 255));
      end
      if (k <= 4) c = 8'h57;
      else if (k <= 8) c = 8'h52;
      else begin
        c = 8'($urandom);
        if (c == 8'h57 || c == 8'h52 || c == 8'h47) c = 8'h00;
      end
      run_cmd(c, ah, al, len, dat, last);
    end
    rand_ready = 1'b0;
    ready_man  = 1'b1;
    tick(2);

    // Boot and CPU access
    cpu_cs_n = 1'b1; cpu_we_n = 1'b1; cpu_oe_n = 1'b1;
    send_byte(8'h47);
    chk("boot_cpu_rst", cpu_rst, 0);
    chk("boot_booted", booted, 1);
    chk("boot_tx_valid", tx_valid, 0);
    cpu_cs_n = 1'b0; cpu_oe_n = 1'b0; cpu_addr = 15'h0011;
    #1;
    chk("run_pass_rd", {mem_cs_n, mem_oe_n, mem_we_n, mem_addr}, {3'b001, 15'h0011});
    tick();
    chk("run_cpu_dout", cpu_dout, ref_mem[15'h0011]);
    cpu_oe_n = 1'b1; cpu_we_n = 1'b0; cpu_addr = 15'h0020; cpu_din = 8'h77;
    #1;
    chk("run_pass_wr", {mem_cs_n, mem_oe_n, mem_we_n, mem_addr, mem_din},
        {3'b010, 15'h0020, 8'h77});
    tick();
    cpu_we_n = 1'b1; cpu_oe_n = 1'b0;
    tick();
    chk("run_readback", cpu_dout, 8'h77);
    cpu_cs_n = 1'b1; cpu_oe_n = 1'b1;
    rx_data = 8'h57; rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("run_rx_blocked%0d", i), {rx_ready, booted}, 2'b01);
    end
    rx_valid = 1'b0;

    chk("strobe_overlap", overlap_err, 0);
    chk("tx_stability", stab_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
